// File: rtl/rk4_step_ctrl.sv
// RK4 step sequencer: runs num_steps steps of four k-stages (go/wait/load), then a y/t update.
// Latency: 3 cycles per stage when alu_done arrives in the first WAIT cycle, 13 per step, start-to-done 13*N+1.
// Backpressure: waits indefinitely on alu_done; start is ignored while a run is active; abort cancels at once.
module rk4_step_ctrl #(
  parameter int STEP_W = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              abort,
  input  logic              alu_done,
  output logic              alu_go,
  output logic [1:0]        stage_sel,
  output logic [3:0]        ld_k,
  output logic              ld_y,
  output logic              ld_t,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GO,
    S_WAIT,
    S_LOAD,
    S_UPD,
    S_DONE
  } state_e;

  localparam logic [STEP_W-1:0] CNT_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [1:0]        stage_q, stage_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [STEP_W-1:0] num_q, num_d;

  // Output registers, loaded from the decode of the next state so every output is a flop.
  logic       alu_go_q, alu_go_d;
  logic [1:0] stage_sel_q, stage_sel_d;
  logic [3:0] ld_k_q, ld_k_d;
  logic       ld_y_q, ld_y_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-state logic: stage sequencing, step counting, abort override.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = num_steps;
          cnt_d   = '0;
          stage_d = 2'd0;
          state_d = (num_steps != '0) ? S_GO : S_DONE;
        end
      end
      S_GO:   state_d = S_WAIT;
      S_WAIT: if (alu_done) state_d = S_LOAD;
      S_LOAD: begin
        if (stage_q == 2'd3) begin
          // The step is counted as it enters the update cycle, so UPD already shows the new count.
          state_d = S_UPD;
          stage_d = 2'd0;
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          state_d = S_GO;
          stage_d = stage_q + 2'd1;
        end
      end
      S_UPD:  state_d = (cnt_q == num_q) ? S_DONE : S_GO;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort beats every other transition; the completed-step count is kept.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      stage_d = 2'd0;
      cnt_d   = cnt_q;
      num_d   = num_q;
    end
  end

  // Output decode of the state being entered.
  always_comb begin
    alu_go_d    = (state_d == S_GO);
    ld_k_d      = (state_d == S_LOAD) ? (4'b0001 << stage_d) : 4'b0000;
    ld_y_d      = (state_d == S_UPD);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d == S_GO) || (state_d == S_WAIT) ||
                  (state_d == S_LOAD) || (state_d == S_UPD);
    stage_sel_d = ((state_d == S_GO) || (state_d == S_WAIT) || (state_d == S_LOAD))
                  ? stage_d : 2'd0;
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= S_IDLE;
      stage_q     <= 2'd0;
      cnt_q       <= '0;
      num_q       <= '0;
      alu_go_q    <= 1'b0;
      stage_sel_q <= 2'd0;
      ld_k_q      <= 4'b0000;
      ld_y_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      alu_go_q    <= alu_go_d;
      stage_sel_q <= stage_sel_d;
      ld_k_q      <= ld_k_d;
      ld_y_q      <= ld_y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign alu_go    = alu_go_q;
  assign stage_sel = stage_sel_q;
  assign ld_k      = ld_k_q;
  assign ld_y      = ld_y_q;
  assign ld_t      = ld_y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step_cnt  = cnt_q;

endmodule

// File: tb/tb_rk4_step_ctrl.sv
// Bench for rk4_step_ctrl: builds the expected per-cycle output timeline of each run from the step rules.
// Latency: not applicable.
// Backpressure: the bench plays the datapath, answering each alu_go after a chosen delay.
module tb_rk4_step_ctrl;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         CLR = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         alu_done = 1'b0;
  logic [W-1:0] num_steps = '0;
  logic         alu_go, ld_y, ld_t, busy, done;
  logic [1:0]   stage_sel;
  logic [3:0]   ld_k;
  logic [W-1:0] step_cnt;

  int checks = 0;
  int errors = 0;

  rk4_step_ctrl #(.STEP_W(W)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .num_steps(num_steps), .abort(abort),
    .alu_done(alu_done), .alu_go(alu_go), .stage_sel(stage_sel), .ld_k(ld_k),
    .ld_y(ld_y), .ld_t(ld_t), .busy(busy), .done(done), .step_cnt(step_cnt)
  );

  always #5 CLK = ~CLK;

  wire [14:0] obs = {done, busy, ld_y, ld_t, ld_k, alu_go, stage_sel, step_cnt};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] pk(input bit dn, input bit by, input bit ly,
                                     input logic [3:0] lk, input bit go,
                                     input int st, input int c);
    logic [1:0]   s2;
    logic [W-1:0] cw;
    s2 = st[1:0];
    cw = c[W-1:0];
    return {dn, by, ly, ly, lk, go, s2, cw};
  endfunction

  // dmode: 0 = answer in first WAIT cycle, 1 = random 0..3 extra, 2 = 4 extra in stage 2 only.
  // rand_ab / rand_rs pick a random abort / restart cycle; ab_at / rs_at / clr_at are directed (-1 = none).
  task automatic run(input int n, input int dmode, input bit strays, input bit rand_ab,
                     input int ab_at_in, input bit rand_rs, input int rs_at_in, input int clr_at);
    logic [14:0] ev [0:699];
    bit          dv [0:699];
    bit          isw [0:699];
    int t, tend, d, ab_at, rs_at, hold;
    for (int i = 0; i < 700; i++) begin
      ev[i] = '0; dv[i] = 1'b0; isw[i] = 1'b0;
    end
    t = 0;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < 4; k++) begin
        if (dmode == 1)                d = int'($urandom_range(0, 3));
        else if (dmode == 2 && k == 2) d = 4;
        else                           d = 0;
        ev[t] = pk(0, 1, 0, 4'b0000, 1, k, s);
        for (int j = 1; j <= d + 1; j++) begin
          ev[t+j]  = pk(0, 1, 0, 4'b0000, 0, k, s);
          isw[t+j] = 1'b1;
        end
        dv[t+1+d]   = 1'b1;
        ev[t+2+d]   = pk(0, 1, 0, 4'b0001 << k, 0, k, s);
        t = t + 3 + d;
      end
      ev[t] = pk(0, 1, 1, 4'b0000, 0, 0, s + 1);
      t++;
    end
    ev[t] = pk(1, 0, 0, 4'b0000, 0, 0, n);
    tend = t + 1;
    ev[tend] = pk(0, 0, 0, 4'b0000, 0, 0, n);
    if (strays)
      for (int i = 0; i <= tend; i++)
        if (!isw[i] && ($urandom_range(0, 1) == 1)) dv[i] = 1'b1;
    ab_at = rand_ab ? int'($urandom_range(0, tend - 1)) : ab_at_in;
    if (ab_at >= 0) begin
      hold = int'(ev[ab_at][W-1:0]);
      tend = ab_at + 1;
      ev[tend] = pk(0, 0, 0, 4'b0000, 0, 0, hold);
    end
    rs_at = rand_rs ? int'($urandom_range(0, tend - 1)) : rs_at_in;

    @(negedge CLK);
    num_steps = n[W-1:0];
    start     = 1'b1;
    alu_done  = strays;
    abort     = 1'b0;
    for (int i = 0; i <= tend; i++) begin
      @(posedge CLK);
      #1;
      start = (i == rs_at);
      num_steps = (i == rs_at) ? 4'd9 : W'($urandom);
      check($sformatf("n%0d_cyc%0d", n, i), obs, ev[i]);
      if (i == clr_at) begin
        #2 CLR = 1'b1;
        #1 check($sformatf("clr_async_n%0d", n), obs, 0);
        alu_done = 1'b0; abort = 1'b0; start = 1'b0;
        @(negedge CLK);
        CLR = 1'b0;
        #1 check("clr_release_idle", obs, 0);
        break;
      end
      alu_done = dv[i];
      abort    = (i == ab_at);
    end
    start = 1'b0; alu_done = 1'b0; abort = 1'b0;
    if (clr_at < 0) begin
      @(negedge CLK);
      check($sformatf("final_cnt_n%0d", n), step_cnt, ev[tend][W-1:0]);
      check($sformatf("final_idle_n%0d", n), {done, busy}, 0);
    end
  endtask

  initial begin
    #2 check("reset_outputs", obs, 0);
    @(negedge CLK);
    CLR = 1'b0;
    #1 check("after_reset_idle", obs, 0);
    run(2, 0, 0, 0, -1, 0, -1, -1);   // two steps, back-to-back answers, done 27 after start
    run(0, 0, 0, 0, -1, 0, -1, -1);   // zero steps: done next cycle, no loads
    run(1, 2, 1, 0, -1, 0, -1, -1);   // stage 2 held five WAIT cycles, stray alu_done ignored
    run(3, 0, 0, 0, 17, 0, -1, -1);   // abort in WAIT of step 2 stage 1
    run(4, 0, 0, 0, -1, 0, -1, 30);   // asynchronous clear during step 3
    run(1, 0, 0, 0, -1, 0, -1, -1);   // fresh start after clear: done 14 after start
    run(2, 0, 0, 0, -1, 0, 5, -1);    // re-start with 9 while busy is ignored
    run(15, 1, 1, 0, -1, 0, -1, -1);  // full-range count with no wrap
    for (int r = 0; r < 14; r++)
      run(int'($urandom_range(0, 15)), 1, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) == 0), -1, 1'($urandom_range(0, 1)), -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
